// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted start strobe, 8-N-1 (or 8-E-1 when
// UART_TX_PARITY_EN is defined), LSB first, line idles high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        T_DATA = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    // Handshake: a request is accepted on any rising edge where the FSM is in
    // IDLE and enable && start are high; busy rises on that edge, and done
    // pulses for one cycle after the stop bit, during which a new request may
    // already be accepted.

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic baud_last;
    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // tx/busy/done are registered, so each branch computes the value the line
    // must carry in the cycle after the edge (i.e. for state_d).
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (enable && start) begin
                    shift_d  = data_in;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = T_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            T_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per request into an 8-N-1 frame (optional even parity), LSB first, on a single-bit line that idles high. It is the transmit-side counterpart of the UART receiver in the same link and shares its frame format and bit period. A host loads a byte with a one-cycle start strobe and watches `busy`/`done`. All timing is derived from one clock divided by a fixed clocks-per-bit count.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk  input  1`: system clock; all logic on rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `enable  input  1`: transmitter enable; `start` is ignored while low.
- `start  input  1`: one-cycle request strobe; sampled only when accepted.
- `data_in  input  8`: byte to send; captured on the accepting edge.
- `tx  output  1`: serial line out; registered; idles at 1.
- `busy  output  1`: high from the accepting edge through the end of the stop bit.
- `done  output  1`: one-cycle pulse when the stop bit completes.

## Operation
- State machine has states IDLE, START, T_DATA, PARITY (only with macro), and STOP.
- IDLE: `tx`=1, `busy`=0. If `enable && start`, capture `data_in` into the shift register, clear the bit counter and baud counter, go to START, and set `busy`=1.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to T_DATA.
- T_DATA: `tx` = shift register bit 0. After CLKS_PER_BIT cycles, shift right and increment the bit index (3 bits). After bit index 7 completes, go to PARITY (macro defined) or STOP.
- PARITY: `tx` = XOR of the captured byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, assert `done`=1, set `busy`=0, and return to IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- `start` while `busy`=1 is ignored; there is no queueing.
- `enable` deasserted mid-frame does not abort the frame. It blocks only new acceptances.
- Reset at any time returns to IDLE with `tx`=1, `busy`=0, `done`=0, and counters and shift register cleared. No partial frame resumes.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0.
- `start` accepted at edge E:
  - `busy`=1 and `tx`=0 are visible after E.
  - Data bit k occupies cycles E+(1+k)·CLKS_PER_BIT .. E+(2+k)·CLKS_PER_BIT-1.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- `done` is high for exactly one cycle, in the cycle after the final stop-bit cycle. `busy` is 0 in that same cycle.
- Back-to-back: `start` with `enable` in the `done` cycle is accepted. The next start bit then begins immediately, with no extra idle bit.
- `data_in` is don't-care except on the accepting edge.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in.
  - An even-parity bit is sent between data bit 7 and the stop bit.
  - Frame is 11 bits.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - T_DATA goes straight to STOP.
  - Frame is 10 bits.

## Test plan
- Basic byte, CLKS_PER_BIT=4, no parity: `start` with `data_in`=0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `busy` high for 40 cycles, then `done` pulses once.
- Busy rejection: send 0x3C, then pulse `start` with 0xFF mid-frame → only 0x3C appears on `tx`. No second frame follows, and `done` pulses once.
- Back-to-back: send 0x00, then assert `start` with 0xFF in the `done` cycle → second start bit begins on the next cycle, with no extra idle bit; `tx` shows 0x00 then 0xFF frames.
- Reset mid-frame: assert `rst` during data bit 3 of 0x55 → `tx`=1, `busy`=0, `done`=0 immediately. A subsequent `start` with 0x81 sends a clean full frame.
- Enable gating: `enable`=0 with `start` pulsed → `tx` stays 1 and `busy` stays 0. Drop `enable` mid-frame → frame completes normally.
- Parity (macro defined): 0x07 → parity bit 1. 0x03 → parity bit 0. Frame is 11·CLKS_PER_BIT cycles.
